// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-client req/ack front end for the SDRAM controller strobe protocol
// SDRAM_ARB_RR_EN selects strict round-robin; undefined gives port-0 priority with a starvation limit.
module sdram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_word,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_word,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_word,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_word_q, mem_word_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                p0_ack_q, p0_ack_d;
    logic                p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic                grant_p1;

`ifdef SDRAM_ARB_RR_EN
    // 1 means port 1 has priority on the next collision
    logic                prio_q, prio_d;
`else
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        mem_word_d = mem_word_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifdef SDRAM_ARB_RR_EN
        prio_d     = prio_q;
        grant_p1   = p1_req && (!p0_req || prio_q);
`else
        starve_d   = starve_q;
        grant_p1   = p1_req && (!p0_req || (starve_q == STARVE_LIM));
`endif

        case (state_q)
            S_IDLE: begin
                // Wait for mem_ready so a strobe never rises into a busy controller
                if ((p0_req || p1_req) && mem_ready) begin
                    port_d     = grant_p1;
                    we_d       = grant_p1 ? p1_we    : p0_we;
                    mem_word_d = grant_p1 ? p1_word  : p0_word;
                    mem_addr_d = grant_p1 ? p1_addr  : p0_addr;
                    mem_din_d  = grant_p1 ? p1_wdata : p0_wdata;
                    mem_wr_d   = grant_p1 ? p1_we    : p0_we;
                    mem_rd_d   = grant_p1 ? !p1_we   : !p0_we;
                    state_d    = S_ACCEPT;
`ifdef SDRAM_ARB_RR_EN
                    prio_d     = !grant_p1;
`else
                    if (grant_p1) begin
                        starve_d = '0;
                    end else if (p1_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 1'b1;
                    end
`endif
                end
            end
            S_ACCEPT: begin
                if (!mem_ready) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    if (port_q) begin
                        p1_ack_d = 1'b1;
                        if (!we_q) p1_rdata_d = mem_dout;
                    end else begin
                        p0_ack_d = 1'b1;
                        if (!we_q) p0_rdata_d = mem_dout;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_word_q <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
`ifdef SDRAM_ARB_RR_EN
            prio_q     <= 1'b0;
`else
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_word_q <= mem_word_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifdef SDRAM_ARB_RR_EN
            prio_q     <= prio_d;
`else
            starve_q   <= starve_d;
`endif
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_word = mem_word_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule
